// File: rtl/edit_pkg.sv
// rtl/edit_pkg.sv - shared mode encoding, field indices, BCD limits and reset values
package edit_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_HORA  = 2'd1,
        MODE_FECHA = 2'd2,
        MODE_TIMER = 2'd3
    } mode_t;

    localparam logic [1:0] POS_LEFT  = 2'd0;
    localparam logic [1:0] POS_MID   = 2'd1;
    localparam logic [1:0] POS_RIGHT = 2'd2;

    localparam int BTN_UP    = 0;
    localparam int BTN_DN    = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    localparam logic [7:0] HOUR_MIN = 8'h00;
    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MS_MIN   = 8'h00;
    localparam logic [7:0] MS_MAX   = 8'h59;
    localparam logic [7:0] DAY_MIN  = 8'h01;
    localparam logic [7:0] DAY_MAX  = 8'h31;
    localparam logic [7:0] MON_MIN  = 8'h01;
    localparam logic [7:0] MON_MAX  = 8'h12;
    localparam logic [7:0] YEAR_MIN = 8'h00;
    localparam logic [7:0] YEAR_MAX = 8'h99;

    localparam logic [23:0] HORA_RST  = 24'h000000;
    localparam logic [23:0] FECHA_RST = 24'h010100;
    localparam logic [23:0] TIMER_RST = 24'h000000;

    // Group index g: 0 hora, 1 fecha, 2 timer; field index f: 0 is leftmost.
    function automatic logic [7:0] fld_min(input int g, input int f);
        if (g == 1) begin
            if (f == 0)      return DAY_MIN;
            else if (f == 1) return MON_MIN;
            else             return YEAR_MIN;
        end
        return (f == 0) ? HOUR_MIN : MS_MIN;
    endfunction

    function automatic logic [7:0] fld_max(input int g, input int f);
        if (g == 1) begin
            if (f == 0)      return DAY_MAX;
            else if (f == 1) return MON_MAX;
            else             return YEAR_MAX;
        end
        return (f == 0) ? HOUR_MAX : MS_MAX;
    endfunction

    function automatic logic [7:0] fld_rst(input int g, input int f);
        logic [23:0] r;
        if (g == 0)      r = HORA_RST;
        else if (g == 1) r = FECHA_RST;
        else             r = TIMER_RST;
        return r[8*(2-f) +: 8];
    endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// rtl/bcd_field_counter.sv - two-digit BCD up/down counter with min/max limits and optional wrap
module bcd_field_counter #(
    parameter logic [7:0] MIN = 8'h00,
    parameter logic [7:0] MAX = 8'h59,
    parameter logic [7:0] RST = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wrap,
    input  logic       up,
    input  logic       down,
    output logic [7:0] value,
    output logic       changed
);

    logic [7:0] value_nx;

    // Packed BCD orders like binary, so limits compare directly.
    always_comb begin
        value_nx = value;
        if (up && !down) begin
            if (value >= MAX)
                value_nx = wrap ? MIN : MAX;
            else if (value[3:0] >= 4'd9)
                value_nx = {value[7:4] + 4'd1, 4'd0};
            else
                value_nx = value + 8'd1;
        end else if (down && !up) begin
            if (value <= MIN)
                value_nx = wrap ? MAX : MIN;
            else if (value[3:0] == 4'd0)
                value_nx = {value[7:4] - 4'd1, 4'd9};
            else
                value_nx = value - 8'd1;
        end
    end

    assign changed = (value_nx != value);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            value <= RST;
        else
            value <= value_nx;
    end

endmodule

// File: rtl/edit_digit_ctrl.sv
// rtl/edit_digit_ctrl.sv - button-driven editor for time, date and timer BCD fields
module edit_digit_ctrl
    import edit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        sw_hora,
    input  logic        sw_fecha,
    input  logic        sw_timer,
    input  logic [3:0]  boton_ed,
    output logic [23:0] hora_bcd,
    output logic [23:0] fecha_bcd,
    output logic [23:0] timer_bcd,
    output logic [1:0]  mode,
    output logic [1:0]  pos,
    output logic [7:0]  dato_print,
    output logic        wr_strobe
);

    mode_t       state, state_nx;
    logic [3:0]  btn_q;
    logic [3:0]  rise;
    logic        active;
    logic        val_up, val_dn, mv_left, mv_right;
    logic [7:0]  val [3][3];
    logic [8:0]  chg;
    logic [23:0] sel_grp;
    logic [7:0]  sel_byte;

    assign rise     = boton_ed & ~btn_q;
    assign active   = (state != MODE_IDLE);
    assign val_up   = active && rise[BTN_UP]   && !rise[BTN_DN];
    assign val_dn   = active && rise[BTN_DN]   && !rise[BTN_UP];
    assign mv_left  = active && rise[BTN_LEFT] && !rise[BTN_RIGHT];
    assign mv_right = active && rise[BTN_RIGHT] && !rise[BTN_LEFT];

    always_comb begin
        state_nx = MODE_IDLE;
        if (sw_hora)
            state_nx = MODE_HORA;
        else if (sw_fecha)
            state_nx = MODE_FECHA;
        else if (sw_timer)
            state_nx = MODE_TIMER;
    end

    // Value edges act on the current state and pos, before the cursor moves.
    for (genvar g = 0; g < 3; g++) begin : g_grp
        for (genvar f = 0; f < 3; f++) begin : g_fld
            logic hit;
            assign hit = (state == mode_t'(g + 1)) && (pos == 2'(f));
            bcd_field_counter #(
                .MIN (fld_min(g, f)),
                .MAX (fld_max(g, f)),
                .RST (fld_rst(g, f))
            ) u_fld (
                .clk     (clk),
                .reset   (reset),
                .wrap    (1'b1),
                .up      (hit && val_up),
                .down    (hit && val_dn),
                .value   (val[g][f]),
                .changed (chg[g*3 + f])
            );
        end
    end

    assign hora_bcd  = {val[0][0], val[0][1], val[0][2]};
    assign fecha_bcd = {val[1][0], val[1][1], val[1][2]};
    assign timer_bcd = {val[2][0], val[2][1], val[2][2]};
    assign mode      = state;

    always_comb begin
        sel_grp = 24'h000000;
        case (state)
            MODE_HORA:  sel_grp = hora_bcd;
            MODE_FECHA: sel_grp = fecha_bcd;
            MODE_TIMER: sel_grp = timer_bcd;
            default:    sel_grp = 24'h000000;
        endcase
        case (pos)
            POS_LEFT: sel_byte = sel_grp[23:16];
            POS_MID:  sel_byte = sel_grp[15:8];
            default:  sel_byte = sel_grp[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= MODE_IDLE;
            btn_q      <= 4'b0000;
            pos        <= POS_LEFT;
            dato_print <= 8'h00;
            wr_strobe  <= 1'b0;
        end else begin
            state      <= state_nx;
            btn_q      <= boton_ed;
            dato_print <= sel_byte;
            wr_strobe  <= |chg;
            if (state_nx != state)
                pos <= POS_LEFT;
            else if (mv_left)
                pos <= (pos == POS_LEFT) ? POS_RIGHT : pos - 2'd1;
            else if (mv_right)
                pos <= (pos == POS_RIGHT) ? POS_LEFT : pos + 2'd1;
        end
    end

endmodule

// File: tb/tb_edit_digit_ctrl.sv
// tb/tb_edit_digit_ctrl.sv - directed self-checking bench for edit_digit_ctrl
module tb_edit_digit_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        sw_hora, sw_fecha, sw_timer;
    logic [3:0]  boton_ed;
    logic [23:0] hora_bcd, fecha_bcd, timer_bcd;
    logic [1:0]  mode, pos;
    logic [7:0]  dato_print;
    logic        wr_strobe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    edit_digit_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .sw_hora    (sw_hora),
        .sw_fecha   (sw_fecha),
        .sw_timer   (sw_timer),
        .boton_ed   (boton_ed),
        .hora_bcd   (hora_bcd),
        .fecha_bcd  (fecha_bcd),
        .timer_bcd  (timer_bcd),
        .mode       (mode),
        .pos        (pos),
        .dato_print (dato_print),
        .wr_strobe  (wr_strobe)
    );

    // One-cycle button pulse; s1 samples wr_strobe right after the action edge, s2 one cycle later.
    task automatic press(input logic [3:0] m, output logic s1, output logic s2);
        @(negedge clk) boton_ed = m;
        @(negedge clk) s1 = wr_strobe;
        boton_ed = 4'b0000;
        @(negedge clk) s2 = wr_strobe;
    endtask

    task automatic set_sw(input logic h, input logic f, input logic t);
        @(negedge clk);
        sw_hora = h; sw_fecha = f; sw_timer = t;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0; boton_ed = 4'b0000;
        sw_hora = 1'b0; sw_fecha = 1'b0; sw_timer = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d want 0", mode); end
        checks++; if (pos !== 2'd0) begin errors++; $display("FAIL reset_pos got %0d want 0", pos); end
        checks++; if (hora_bcd !== 24'h000000) begin errors++; $display("FAIL reset_hora got %h want 000000", hora_bcd); end
        checks++; if (fecha_bcd !== 24'h010100) begin errors++; $display("FAIL reset_fecha got %h want 010100", fecha_bcd); end
        checks++; if (timer_bcd !== 24'h000000) begin errors++; $display("FAIL reset_timer got %h want 000000", timer_bcd); end
        checks++; if (dato_print !== 8'h00) begin errors++; $display("FAIL reset_dato got %h want 00", dato_print); end
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", wr_strobe); end
    endtask

    task automatic test_idle_ignore;
        logic s1, s2;
        press(4'b0001, s1, s2);
        checks++; if (hora_bcd !== 24'h000000) begin errors++; $display("FAIL idle_hora got %h want 000000", hora_bcd); end
        checks++; if (s1 !== 1'b0) begin errors++; $display("FAIL idle_strobe got %b want 0", s1); end
    endtask

    task automatic test_hora_wrap;
        logic s1, s2;
        set_sw(1'b1, 1'b0, 1'b0);
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL hora_mode got %0d want 1", mode); end
        press(4'b0010, s1, s2);
        checks++; if (hora_bcd !== 24'h230000) begin errors++; $display("FAIL hora_down_wrap got %h want 230000", hora_bcd); end
        checks++; if (dato_print !== 8'h23) begin errors++; $display("FAIL hora_dato got %h want 23", dato_print); end
        press(4'b0001, s1, s2);
        checks++; if (hora_bcd[23:16] !== 8'h00) begin errors++; $display("FAIL hora_up_wrap got %h want 00", hora_bcd[23:16]); end
        checks++; if (s1 !== 1'b1 || s2 !== 1'b0) begin errors++; $display("FAIL hora_strobe got %b%b want 10", s1, s2); end
        press(4'b1000, s1, s2);
        checks++; if (pos !== 2'd1) begin errors++; $display("FAIL hora_right got %0d want 1", pos); end
        checks++; if (s1 !== 1'b0) begin errors++; $display("FAIL cursor_strobe got %b want 0", s1); end
        press(4'b0001, s1, s2);
        checks++; if (hora_bcd !== 24'h000100) begin errors++; $display("FAIL hora_min_up got %h want 000100", hora_bcd); end
        checks++; if (dato_print !== 8'h01) begin errors++; $display("FAIL hora_min_dato got %h want 01", dato_print); end
    endtask

    task automatic test_fecha_limits;
        logic s1, s2;
        set_sw(1'b0, 1'b1, 1'b0);
        checks++; if (mode !== 2'd2 || pos !== 2'd0) begin errors++; $display("FAIL fecha_entry got mode %0d pos %0d want 2 0", mode, pos); end
        press(4'b1000, s1, s2);
        press(4'b0010, s1, s2);
        checks++; if (fecha_bcd !== 24'h011200) begin errors++; $display("FAIL fecha_month got %h want 011200", fecha_bcd); end
        press(4'b0100, s1, s2);
        press(4'b0010, s1, s2);
        checks++; if (fecha_bcd !== 24'h311200) begin errors++; $display("FAIL fecha_day got %h want 311200", fecha_bcd); end
        press(4'b0100, s1, s2);
        press(4'b0010, s1, s2);
        checks++; if (fecha_bcd !== 24'h311299) begin errors++; $display("FAIL fecha_year got %h want 311299", fecha_bcd); end
        checks++; if (hora_bcd !== 24'h000100) begin errors++; $display("FAIL hora_retained got %h want 000100", hora_bcd); end
    endtask

    task automatic test_priority;
        logic s1, s2;
        set_sw(1'b1, 1'b0, 1'b1);
        checks++; if (mode !== 2'd1 || pos !== 2'd0) begin errors++; $display("FAIL prio_entry got mode %0d pos %0d want 1 0", mode, pos); end
        press(4'b0100, s1, s2);
        checks++; if (mode !== 2'd1 || pos !== 2'd2) begin errors++; $display("FAIL prio_left_wrap got mode %0d pos %0d want 1 2", mode, pos); end
        set_sw(1'b0, 1'b0, 1'b1);
        checks++; if (mode !== 2'd3 || pos !== 2'd0) begin errors++; $display("FAIL prio_timer got mode %0d pos %0d want 3 0", mode, pos); end
    endtask

    task automatic test_held_and_conflict;
        int pulses;
        pulses = 0;
        @(negedge clk) boton_ed = 4'b0001;
        repeat (100) begin
            @(negedge clk);
            if (wr_strobe === 1'b1) pulses++;
        end
        boton_ed = 4'b0000;
        @(negedge clk);
        checks++; if (timer_bcd !== 24'h010000) begin errors++; $display("FAIL held_value got %h want 010000", timer_bcd); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL held_pulses got %0d want 1", pulses); end
        @(negedge clk) boton_ed = 4'b0011;
        @(negedge clk);
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL conflict_strobe got %b want 0", wr_strobe); end
        boton_ed = 4'b0000;
        @(negedge clk);
        checks++; if (timer_bcd !== 24'h010000) begin errors++; $display("FAIL conflict_value got %h want 010000", timer_bcd); end
    endtask

    task automatic test_combined;
        logic s1, s2;
        press(4'b1000, s1, s2);
        press(4'b0010, s1, s2);
        checks++; if (timer_bcd !== 24'h015900) begin errors++; $display("FAIL comb_setup got %h want 015900", timer_bcd); end
        press(4'b1001, s1, s2);
        checks++; if (timer_bcd !== 24'h010000) begin errors++; $display("FAIL comb_value got %h want 010000", timer_bcd); end
        checks++; if (pos !== 2'd2) begin errors++; $display("FAIL comb_pos got %0d want 2", pos); end
        checks++; if (s1 !== 1'b1) begin errors++; $display("FAIL comb_strobe got %b want 1", s1); end
    endtask

    task automatic test_reset_mid_edit;
        logic s1, s2;
        int pulses;
        set_sw(1'b1, 1'b0, 1'b0);
        repeat (12) press(4'b0001, s1, s2);
        press(4'b1000, s1, s2);
        repeat (33) press(4'b0001, s1, s2);
        press(4'b1000, s1, s2);
        repeat (4) press(4'b0010, s1, s2);
        checks++; if (hora_bcd !== 24'h123456) begin errors++; $display("FAIL mid_setup got %h want 123456", hora_bcd); end
        @(negedge clk) boton_ed = 4'b0001;
        #1 reset = 1'b0;
        #1;
        checks++; if (hora_bcd !== 24'h000000 || fecha_bcd !== 24'h010100 || timer_bcd !== 24'h000000)
            begin errors++; $display("FAIL mid_groups got %h %h %h want 000000 010100 000000", hora_bcd, fecha_bcd, timer_bcd); end
        checks++; if (mode !== 2'd0 || pos !== 2'd0 || dato_print !== 8'h00 || wr_strobe !== 1'b0)
            begin errors++; $display("FAIL mid_ctrl got mode %0d pos %0d dato %h strobe %b", mode, pos, dato_print, wr_strobe); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (wr_strobe === 1'b1) pulses++;
        end
        checks++; if (hora_bcd !== 24'h000000) begin errors++; $display("FAIL mid_no_incr got %h want 000000", hora_bcd); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_pulses got %0d want 0", pulses); end
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL mid_mode got %0d want 1", mode); end
        boton_ed = 4'b0000;
    endtask

    initial begin
        test_reset;
        test_idle_ignore;
        test_hora_wrap;
        test_fecha_limits;
        test_priority;
        test_held_and_conflict;
        test_combined;
        test_reset_mid_edit;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
